// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 1-bit/clock 32-bit shifter; SRA fill enabled by SHIFT_SEQ_SRA_EN
module shift_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state;
  logic [31:0] w, w_nxt;
  logic [4:0]  c;
  logic [1:0]  op_q;
  always_comb begin
`ifdef SHIFT_SEQ_SRA_EN
    w_nxt = op_q == 2'b01 ? {w[30:0], 1'b0} : {op_q == 2'b10 && w[31], w[31:1]};
`else
    w_nxt = op_q == 2'b01 ? {w[30:0], 1'b0} : {1'b0, w[31:1]};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      w      <= '0;
      c      <= '0;
      op_q   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          w    <= a;
          c    <= shamt;
          op_q <= op;
          busy <= 1'b1;
          if (shamt == 5'd0) begin
            state  <= DONE;
            result <= a;
            done   <= 1'b1;
          end else state <= SHIFT;
        end
        SHIFT: begin
          w <= w_nxt;
          c <= c - 5'd1;
          if (c == 5'd1) begin
            state  <= DONE;
            result <= w_nxt;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks against an arithmetic shift model
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] a = '0;
  logic        busy, done;
  logic [31:0] result;
  int          errors = 0;
  int          checks = 0;

  shift_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .shamt(shamt), .a(a),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] av, input int s, input logic [1:0] o);
    logic [31:0] r;
    r = av >> s;
`ifdef SHIFT_SEQ_SRA_EN
    if (o == 2'b10) r = $unsigned($signed(av) >>> s);
`endif
    if (o == 2'b01) r = av << s;
    return r;
  endfunction

  // mode 0: quiet; 1: random noise on inputs while busy; 2: start pulses in cycle 3 and the DONE cycle
  task automatic run_op(input logic [31:0] av, input logic [4:0] s, input logic [1:0] o, input int mode);
    logic [31:0] exp;
    int n;
    exp = model(av, int'(s), o);
    n = int'(s) + 1;
    a = av; shamt = s; op = o; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(k == n));
      if (k == n) check("result", result, exp);
      start = 1'b0;
      if (mode == 1) begin
        start = 1'($urandom); a = $urandom; shamt = 5'($urandom); op = 2'($urandom);
      end else if (mode == 2) begin
        start = (k + 1 == 3) || (k + 1 == n);
        a = 32'h12345678; shamt = 5'd3;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_idle", 32'(busy), 32'd0);
    check("done_idle", 32'(done), 32'd0);
    check("result_hold", result, exp);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h80000000, 5'd31, 2'b00, 0);
    check("srl31", result, 32'h00000001);
    run_op(32'h00000001, 5'd5, 2'b01, 0);
    check("sll5", result, 32'h00000020);
    run_op(32'hDEADBEEF, 5'd0, 2'b01, 0);
    check("sll0", result, 32'hDEADBEEF);
    run_op(32'h80000000, 5'd4, 2'b10, 0);
`ifdef SHIFT_SEQ_SRA_EN
    check("sra4", result, 32'hF8000000);
`else
    check("sra4", result, 32'h08000000);
`endif
    run_op(32'hFFFF0000, 5'd8, 2'b00, 2);
    check("busy_start", result, 32'h00FFFF00);
    run_op(32'h80000000, 5'd1, 2'b11, 0);
    check("reserved", result, 32'h40000000);
    a = 32'hCAFEF00D; shamt = 5'd20; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'h0);
    for (int k = 0; k < 25; k++) begin
      check("abort_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    run_op(32'h0000000F, 5'd1, 2'b00, 0);
    check("after_abort", result, 32'h00000007);
    for (int i = 0; i < 40; i++)
      run_op($urandom, 5'($urandom), 2'($urandom), int'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle variable-amount 32-bit shifter built around the single-bit shift stage of the ALU datapath. It accepts an operand, shift amount and shift type, then applies one 1-bit shift per clock until the requested amount is reached. It reports completion with a start/busy/done handshake, and its result feeds the ALU result mux. It replaces a full barrel shifter where area matters more than latency.

## Interface
- No parameters; data width fixed at 32, shift amount fixed at 5 bits.
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high
- start  input  1  request; sampled only while busy=0
- op  input  2  shift type: 00 SRL, 01 SLL, 10 SRA, 11 reserved
- shamt  input  5  shift amount, 0–31
- a  input  32  operand
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- result  output  32  shifted value; held until the next completion

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Load working register W with a, counter C with shamt, and latch op.
  - Next state is SHIFT if shamt≠0, else DONE.
- IDLE, start=0: remain in IDLE.
- SHIFT, each cycle: update W by one bit, decrement C, and go to DONE when C=1.
  - SRL: W = {1'b0, W[31:1]}.
  - SLL: W = {W[30:0], 1'b0}.
  - SRA: W = {W[31], W[31:1]}. Requires the macro; see Configuration.
  - Reserved op 11 behaves as SRL.
- DONE: result ← W, done=1 for exactly this cycle, next state IDLE.
- start while busy=1 (SHIFT or DONE) is ignored. It is not queued, and a, shamt and op are not resampled.
- Inputs a, shamt and op may change freely after acceptance; only the captured copies are used.
- Counter is 5 bits and never wraps: the SHIFT exit at C=1 prevents decrement below 1.
- rst=1 in any state at a clock edge:
  - State → IDLE; W, C, result → 0; busy=0, done=0.
  - No done pulse is issued for the aborted operation.

## Timing
- Reset values: busy=0, done=0, result=32'h0.
- Accept edge E0 is the edge where start=1 and state is IDLE. busy goes high after E0.
- done is high during cycle shamt+1 after E0, i.e. latency = shamt+1 cycles.
  - shamt=0: done in the cycle immediately after E0, with result=a.
  - shamt=31: done 32 cycles after E0.
- result updates on the same edge that raises done, and is stable from then until the next completion.
- busy falls on the edge ending the DONE cycle. The earliest next accept is that following edge, so back-to-back throughput is one operation per shamt+2 cycles.
- done and busy are registered outputs. There is no combinational path from inputs to outputs.

## Configuration
- Macro SHIFT_SEQ_SRA_EN.
- Defined: op=10 performs arithmetic right shift, replicating W[31] each cycle.
- Undefined: op=10 is treated as SRL, and the sign-fill logic is not synthesized.
- All other behaviour and timing are identical in both builds.

## Test plan
- SRL: a=32'h80000000, shamt=31, op=00 → done 32 cycles after accept, result=32'h00000001, busy high for cycles 1–32.
- SLL with zero shift: a=32'h00000001, shamt=5, op=01 → result=32'h00000020 after 6 cycles. Then a=32'hDEADBEEF, shamt=0 → done next cycle, result=32'hDEADBEEF.
- SRA: a=32'h80000000, shamt=4, op=10 → result=32'hF8000000 with SHIFT_SEQ_SRA_EN defined, 32'h08000000 without it.
- Start while busy: accept a=32'hFFFF0000, shamt=8, op=00. Pulse start with different a and shamt in cycles 3 and 9 (the DONE cycle) → exactly one done, result=32'h00FFFF00. The next start is accepted only after busy falls.
- Reset mid-operation: accept shamt=20, assert rst in cycle 10 → next cycle busy=0, done=0, result=0, and no done pulse follows. A new op (a=32'h0000000F, shamt=1, SRL) then yields 32'h00000007.
- Reserved op: op=11, a=32'h80000000, shamt=1 → result=32'h40000000 in both builds.
